// File: rtl/minisys_pkg.sv
// Shared Minisys-1A pipeline constants: next-PC select codes, the NOP
// encoding and the fetch FSM state type.
package minisys_pkg;

   localparam logic [1:0]  WPC_SEQ   = 2'b00;
   localparam logic [1:0]  WPC_BR    = 2'b01;
   localparam logic [1:0]  WPC_JMP   = 2'b10;
   localparam logic [1:0]  WPC_REG   = 2'b11;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC generation: sequential, branch, jump and register
// targets from the IF/ID contents, and the selected next PC.
module pc_target_calc
   import minisys_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr,
   input  logic [31:2] rs_data,
   input  logic [1:0]  sel,
   output logic [31:0] seq_target,
   output logic [31:0] next_pc
);

   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] reg_target;

   // All targets are modulo 2^32; the branch offset is a sign-extended word offset.
   assign seq_target = pc + 32'd4;
   assign br_target  = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign reg_target = {rs_data[31:2], 2'b00};

   always_comb begin
      next_pc = seq_target;
      unique case (sel)
         WPC_BR:  next_pc = br_target;
         WPC_JMP: next_pc = jmp_target;
         WPC_REG: next_pc = reg_target;
         default: next_pc = seq_target;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC register and IF/ID pipeline register with redirect handling,
// wrong-path squash and a saturating redirect counter.
module pc_fetch_unit
   import minisys_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             IF_WPC,
   input  logic [1:0]       Wpc,
   input  logic             IF_flush,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      imem_addr,
   output logic [31:0]      IF_ID_instr,
   output logic [5:0]       IF_ID_op,
   output logic [31:0]      IF_ID_pc_plus4,
   output logic             IF_ID_valid,
   output logic [31:0]      link_addr,
   output logic [CNT_W-1:0] redirect_cnt
);

   fetch_state_e     state;
   fetch_state_e     next_state;
   logic             load_en;
   logic [1:0]       wpc_eff;
   logic             flush_eff;

   logic [31:0]      pc_q;
   logic [31:0]      instr_q;
   logic [31:0]      pc4_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;

   logic [31:0]      seq_target;
   logic [31:0]      next_pc;

   // Redirect/flush requests only count against a real instruction in RUN.
   always_comb begin
      next_state = state;
      load_en    = 1'b0;
      wpc_eff    = WPC_SEQ;
      flush_eff  = 1'b0;
      unique case (state)
         BOOT: next_state = RUN;
         RUN: begin
            load_en = IF_WPC;
            if (valid_q) begin
               wpc_eff   = Wpc;
               flush_eff = IF_flush;
            end
         end
         default: next_state = BOOT;
      endcase
   end

   pc_target_calc u_target (
      .pc         (pc_q),
      .pc_plus4   (pc4_q),
      .instr      (instr_q[25:0]),
      .rs_data    (rs_data[31:2]),
      .sel        (wpc_eff),
      .seq_target (seq_target),
      .next_pc    (next_pc)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state <= next_state;
         if (load_en) begin
            pc_q <= next_pc;
            if (flush_eff) begin
               instr_q <= NOP_INSTR;
               pc4_q   <= '0;
               valid_q <= 1'b0;
            end else begin
               instr_q <= imem_rdata;
               pc4_q   <= seq_target;
               valid_q <= 1'b1;
            end
            if (wpc_eff != WPC_SEQ && !(&cnt_q))
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign imem_addr      = pc_q;
   assign IF_ID_instr    = instr_q;
   assign IF_ID_op       = instr_q[31:26];
   assign IF_ID_pc_plus4 = pc4_q;
   assign IF_ID_valid    = valid_q;
   assign link_addr      = pc4_q;
   assign redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random
// stimulus against a behavioural pipeline model; a CNT_W=2 copy checks saturation.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_wpc;
   logic [1:0]  wpc;
   logic        if_flush;
   logic [31:0] rs_data;
   logic [31:0] imem_rdata;

   logic [31:0] imem_addr, instr, pc4, link;
   logic [5:0]  op;
   logic        valid;
   logic [15:0] cnt;

   logic [31:0] imem_addr2, instr2, pc42, link2;
   logic [5:0]  op2;
   logic        valid2;
   logic [1:0]  cnt2;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   bit          m_boot;
   logic [31:0] m_pc, m_instr, m_pc4;
   bit          m_valid;
   int unsigned m_redirects;

   always #5 clock = ~clock;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .IF_WPC(if_wpc), .Wpc(wpc), .IF_flush(if_flush),
      .rs_data(rs_data), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
      .IF_ID_instr(instr), .IF_ID_op(op), .IF_ID_pc_plus4(pc4), .IF_ID_valid(valid),
      .link_addr(link), .redirect_cnt(cnt)
   );

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .IF_WPC(if_wpc), .Wpc(wpc), .IF_flush(if_flush),
      .rs_data(rs_data), .imem_rdata(imem_rdata), .imem_addr(imem_addr2),
      .IF_ID_instr(instr2), .IF_ID_op(op2), .IF_ID_pc_plus4(pc42), .IF_ID_valid(valid2),
      .link_addr(link2), .redirect_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock of the architectural rules, applied to the current inputs.
   task automatic model_edge();
      logic [1:0]  w;
      bit          f;
      logic [31:0] npc;
      if (!reset) begin
         m_boot = 1; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
         m_valid = 0; m_redirects = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (if_wpc) begin
         w = m_valid ? wpc : 2'b00;
         f = m_valid && if_flush;
         case (w)
            2'b01:   npc = m_pc4 + 32'($signed(m_instr[15:0])) * 32'd4;
            2'b10:   npc = {m_pc4[31:28], m_instr[25:0], 2'b00};
            2'b11:   npc = rs_data & 32'hFFFF_FFFC;
            default: npc = m_pc + 32'd4;
         endcase
         if (w != 2'b00) m_redirects++;
         if (f) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
         end else begin
            m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1;
         end
         m_pc = npc;
      end
   endtask

   task automatic compare_all();
      int unsigned c16;
      int unsigned c2;
      c16 = (m_redirects > 65535) ? 65535 : m_redirects;
      c2  = (m_redirects > 3) ? 3 : m_redirects;
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", instr, m_instr);
      check("if_id_op", {26'b0, op}, {26'b0, m_instr[31:26]});
      check("if_id_pc_plus4", pc4, m_pc4);
      check("if_id_valid", {31'b0, valid}, {31'b0, m_valid});
      check("link_addr", link, m_pc4);
      check("redirect_cnt", {16'b0, cnt}, c16);
      check("redirect_cnt_w2", {30'b0, cnt2}, c2);
      check("w2_imem_addr", imem_addr2, m_pc);
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic drive(input logic r, input logic we, input logic [1:0] w,
                        input logic fl, input logic [31:0] rs, input logic [31:0] rd);
      reset = r; if_wpc = we; wpc = w; if_flush = fl; rs_data = rs; imem_rdata = rd;
   endtask

   // Land instruction `ins` in IF/ID with pc_plus4 = addr+4.
   task automatic place(input logic [31:0] addr, input logic [31:0] ins);
      if (!m_valid) begin
         drive(1, 1, 2'b00, 0, 32'h0, 32'h0000_0001);
         step();
      end
      drive(1, 1, 2'b11, 1, addr, 32'hDEAD_BEEF);
      step();
      drive(1, 1, 2'b00, 0, 32'h0, ins);
      step();
   endtask

   initial begin
      drive(0, 1, 2'b00, 0, 32'h0, 32'h2001_0005);
      // Reset for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_addr", imem_addr, 32'h0);
         check("reset_valid", {31'b0, valid}, 32'h0);
         check("reset_cnt", {16'b0, cnt}, 32'h0);
      end
      drive(1, 1, 2'b00, 0, 32'h0, 32'h2001_0005);
      step();
      check("boot_hold_addr", imem_addr, 32'h0);
      check("boot_bubble", {31'b0, valid}, 32'h0);
      step();
      check("first_instr", instr, 32'h2001_0005);
      check("first_pc4", pc4, 32'h4);

      // Taken beq
      place(32'h0000_0010, 32'h1000_0003);
      check("beq_pc4", pc4, 32'h14);
      begin
         int unsigned base;
         base = m_redirects;
         drive(1, 1, 2'b01, 1, 32'h0, 32'h1234_5678);
         step();
         check("beq_target", imem_addr, 32'h20);
         check("beq_bubble", {31'b0, valid}, 32'h0);
         check("beq_cnt_inc", {16'b0, cnt}, base + 1);
      end

      // jal then jr
      place(32'h0000_0004, 32'h0C00_0040);
      check("jal_link", link, 32'h8);
      drive(1, 1, 2'b10, 1, 32'h0, 32'h0);
      step();
      check("jal_target", imem_addr, 32'h100);
      place(32'h0000_0040, 32'h0000_0008);
      drive(1, 1, 2'b11, 1, 32'h0000_002E, 32'h0);
      step();
      check("jr_target", imem_addr, 32'h2C);

      // Stall versus redirect, then bubble qualification
      place(32'h0000_0010, 32'h1000_0003);
      begin
         int unsigned base;
         base = m_redirects;
         drive(1, 0, 2'b01, 1, 32'h0, 32'h5555_AAAA);
         step();
         step();
         check("stall_addr", imem_addr, 32'h14);
         check("stall_instr", instr, 32'h1000_0003);
         check("stall_cnt", {16'b0, cnt}, base);
         if_wpc = 1;
         step();
         check("post_stall_target", imem_addr, 32'h20);
         check("post_stall_cnt", {16'b0, cnt}, base + 1);
         drive(1, 1, 2'b10, 1, 32'h0, 32'h2002_0007);
         step();
         check("bubble_seq_addr", imem_addr, 32'h24);
         check("bubble_latched", instr, 32'h2002_0007);
         check("bubble_cnt", {16'b0, cnt}, base + 1);
      end

      // PC wrap
      place(32'hFFFF_FFF8, 32'h0);
      check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
      drive(1, 1, 2'b00, 0, 32'h0, 32'h0);
      step();
      check("wrap_zero", imem_addr, 32'h0);

      // Counter saturation (CNT_W=2 copy) after fresh reset + 5 redirects
      drive(0, 1, 2'b00, 0, 32'h0, 32'h0);
      step();
      drive(1, 1, 2'b00, 0, 32'h0, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 2'b00, 0, 32'h0, 32'h0);
         step();
         drive(1, 1, 2'b11, 1, 32'h100, 32'h0);
         step();
      end
      check("sat_w2", {30'b0, cnt2}, 32'h3);
      check("sat_w16", {16'b0, cnt}, 32'h5);

      // Reset during a redirect cycle
      place(32'h0000_0010, 32'h1000_0003);
      drive(0, 1, 2'b01, 1, 32'h0, 32'h0);
      step();
      check("rst_redirect_addr", imem_addr, 32'h0);
      check("rst_redirect_valid", {31'b0, valid}, 32'h0);
      check("rst_redirect_cnt", {16'b0, cnt}, 32'h0);
      drive(1, 1, 2'b00, 0, 32'h0, 32'h0);
      step();

      // Random stimulus
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
               2'($urandom), 1'($urandom), $urandom, $urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
